// File: rtl/float_packer.sv
// Pipelined signed fixed-point to IEEE-754 single converter, three lockstep lanes.
// Edge N samples the inputs (S1); the rounded words reach the outputs after edge N+5.
module float_packer #(
  parameter int FRAC_BITS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_pack,
  input  logic [31:0] fx1,
  input  logic [31:0] fx2,
  input  logic [31:0] fx3,
  output logic        valid_pack,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [31:0] val3
);

  localparam logic signed [9:0] EXP_OFF = 10'(127 - FRAC_BITS);

  function automatic logic [4:0] lead_one(input logic [31:0] m);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) p = 5'(i);
    end
    return p;
  endfunction

  logic               s1_valid, s2_valid, s3_valid, s4_valid, s5_valid;
  logic [31:0]        s1_fx    [3];
  logic               s2_sign  [3];
  logic [31:0]        s2_mag   [3];
  logic               s3_sign  [3];
  logic [31:0]        s3_mag   [3];
  logic [4:0]         s3_pos   [3];
  logic               s3_zero  [3];
  logic               s4_sign  [3];
  logic               s4_zero  [3];
  logic [22:0]        s4_mant  [3];
  logic               s4_guard [3];
  logic               s4_sticky[3];
  logic signed [9:0]  s4_exp   [3];
  logic [31:0]        s5_word  [3];
  logic [31:0]        out_word [3];

  logic [31:0]        abs_mag  [3];
  logic [31:0]        norm     [3];
  logic [23:0]        mant_sum [3];
  logic signed [9:0]  exp_rnd  [3];
  logic [31:0]        word     [3];

  // Per-lane combinational work feeding S2, S4 and S5.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      abs_mag[i]  = s1_fx[i][31] ? (~s1_fx[i] + 32'd1) : s1_fx[i];
      norm[i]     = s3_mag[i] << (5'd31 - s3_pos[i]);
      mant_sum[i] = {1'b0, s4_mant[i]} +
                    24'(s4_guard[i] & (s4_sticky[i] | s4_mant[i][0]));
      exp_rnd[i]  = s4_exp[i] + $signed({9'b0, mant_sum[i][23]});
      word[i]     = {s4_sign[i], exp_rnd[i][7:0], mant_sum[i][22:0]};
      if (s4_zero[i] || exp_rnd[i] < 10'sd1) begin
        word[i] = 32'h0000_0000;
      end else if (exp_rnd[i] > 10'sd254) begin
        word[i] = {s4_sign[i], 8'hFE, 23'h7F_FFFF};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      s4_valid   <= 1'b0;
      s5_valid   <= 1'b0;
      valid_pack <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        s1_fx[i]     <= '0;
        s2_sign[i]   <= 1'b0;
        s2_mag[i]    <= '0;
        s3_sign[i]   <= 1'b0;
        s3_mag[i]    <= '0;
        s3_pos[i]    <= '0;
        s3_zero[i]   <= 1'b1;
        s4_sign[i]   <= 1'b0;
        s4_zero[i]   <= 1'b1;
        s4_mant[i]   <= '0;
        s4_guard[i]  <= 1'b0;
        s4_sticky[i] <= 1'b0;
        s4_exp[i]    <= '0;
        s5_word[i]   <= '0;
        out_word[i]  <= '0;
      end
    end else begin
      s1_valid   <= enable_pack;
      s2_valid   <= s1_valid;
      s3_valid   <= s2_valid;
      s4_valid   <= s3_valid;
      s5_valid   <= s4_valid;
      valid_pack <= s5_valid;
      if (enable_pack) begin
        s1_fx[0] <= fx1;
        s1_fx[1] <= fx2;
        s1_fx[2] <= fx3;
      end
      // A stage only loads when its upstream valid is set, so idle cycles hold data.
      for (int i = 0; i < 3; i++) begin
        if (s1_valid) begin
          s2_sign[i] <= s1_fx[i][31];
          s2_mag[i]  <= abs_mag[i];
        end
        if (s2_valid) begin
          s3_sign[i] <= s2_sign[i];
          s3_mag[i]  <= s2_mag[i];
          s3_pos[i]  <= lead_one(s2_mag[i]);
          s3_zero[i] <= (s2_mag[i] == 32'd0);
        end
        if (s3_valid) begin
          s4_sign[i]   <= s3_sign[i];
          s4_zero[i]   <= s3_zero[i];
          s4_mant[i]   <= norm[i][30:8];
          s4_guard[i]  <= norm[i][7];
          s4_sticky[i] <= |norm[i][6:0];
          s4_exp[i]    <= $signed({5'b0, s3_pos[i]}) + EXP_OFF;
        end
        if (s4_valid) s5_word[i] <= word[i];
        if (s5_valid) out_word[i] <= s5_word[i];
      end
    end
  end

  assign val1 = out_word[0];
  assign val2 = out_word[1];
  assign val3 = out_word[2];

endmodule

// File: tb/tb_float_packer.sv
// Self-checking bench for float_packer: directed values, randomized streaming
// against an arithmetic reference model, and reset behaviour.
module tb_float_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable_pack = 1'b0;
  logic [31:0] fx1 = '0, fx2 = '0, fx3 = '0;
  logic        valid_pack;
  logic [31:0] val1, val2, val3;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  bit          sch_v [64];
  logic [95:0] sch_w [64];

  float_packer #(.FRAC_BITS(24)) dut (
    .clk(clk), .reset(reset), .enable_pack(enable_pack),
    .fx1(fx1), .fx2(fx2), .fx3(fx3),
    .valid_pack(valid_pack), .val1(val1), .val2(val2), .val3(val3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Value = fx / 2^24, rounded to 24 significant bits, ties to even.
  function automatic logic [31:0] fp_model(input logic [31:0] fx);
    longint v, mag, q, r, half;
    int p, e, sh;
    v   = longint'($signed(fx));
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 32'h0;
    p = 0;
    while ((longint'(1) << (p + 1)) <= mag) p++;
    e  = p - 24 + 127;
    sh = p - 23;
    if (sh <= 0) begin
      q = mag << (-sh);
    end else begin
      q    = mag >> sh;
      r    = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && (q % 2) == 1)) q++;
    end
    if (q == (longint'(1) << 24)) begin
      q = longint'(1) << 23;
      e++;
    end
    return {fx[31], 8'(e), 23'(q)};
  endfunction

  function automatic logic [31:0] rand_fx();
    logic [31:0] x;
    case ($urandom_range(0, 5))
      0: x = $urandom();
      1: x = 32'($urandom_range(0, 255));
      2: x = $urandom() >> $urandom_range(0, 31);
      3: x = -($urandom() >> $urandom_range(0, 31));
      4: x = ($urandom() & 32'hFFFF_FF00) | 32'h0000_0080;
      default: x = (($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0);
    endcase
    return x;
  endfunction

  task automatic drive(input bit en, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    enable_pack = en;
    fx1 = a;
    fx2 = b;
    fx3 = c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (valid_pack !== 1'b0 || {val1, val2, val3} !== 96'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: valid=%b vals=%h %h %h, want 0", valid_pack, val1, val2, val3);
    end
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests_run++;
      if (valid_pack !== 1'b0 || {val1, val2, val3} !== 96'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset_release cycle %0d: valid=%b vals=%h %h %h, want 0",
                 k, valid_pack, val1, val2, val3);
      end
    end
  endtask

  task automatic test_directed_values();
    logic [31:0] ins [3][3];
    logic [31:0] exps [3][3];
    ins[0]  = '{32'h0100_0000, 32'hFF00_0000, 32'h0080_0000};
    exps[0] = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F00_0000};
    ins[1]  = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001};
    exps[1] = '{32'h0000_0000, 32'hC300_0000, 32'h3380_0000};
    ins[2]  = '{32'h7FFF_FFFF, 32'h4000_0040, 32'h4000_00C0};
    exps[2] = '{32'h4300_0000, 32'h4280_0000, 32'h4280_0002};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      drive(1'b1, ins[t][0], ins[t][1], ins[t][2]);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      for (int k = 1; k < 5; k++) begin
        tests_run++;
        if (valid_pack !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL early_strobe row %0d after %0d edges: valid=%b want 0", t, k, valid_pack);
        end
        @(negedge clk);
      end
      @(negedge clk);
      tests_run++;
      if (valid_pack !== 1'b1 || {val1, val2, val3} !== {exps[t][0], exps[t][1], exps[t][2]}) begin
        tests_failed++;
        $display("[TB] FAIL directed row %0d: valid=%b vals=%h %h %h, want 1 %h %h %h", t,
                 valid_pack, val1, val2, val3, exps[t][0], exps[t][1], exps[t][2]);
      end
      @(negedge clk);
      tests_run++;
      if (valid_pack !== 1'b0 || {val1, val2, val3} !== {exps[t][0], exps[t][1], exps[t][2]}) begin
        tests_failed++;
        $display("[TB] FAIL hold row %0d: valid=%b vals=%h %h %h, want 0 %h %h %h", t,
                 valid_pack, val1, val2, val3, exps[t][0], exps[t][1], exps[t][2]);
      end
    end
  endtask

  // 8 on, 2 off, 3 on, then random enables, then drain; outputs expected 6 negedges later.
  task automatic test_stream();
    logic [95:0] hold;
    bit          have_hold;
    bit          en;
    int          s;
    logic [31:0] a, b, c;
    int          strobes;
    have_hold = 1'b0;
    hold      = '0;
    strobes   = 0;
    for (int i = 0; i < 64; i++) sch_v[i] = 1'b0;
    for (int k = 0; k < 61; k++) begin
      @(negedge clk);
      s = cyc % 64;
      tests_run++;
      if (valid_pack !== sch_v[s]) begin
        tests_failed++;
        $display("[TB] FAIL stream_valid step %0d: got %b want %b", k, valid_pack, sch_v[s]);
      end else if (sch_v[s]) begin
        strobes++;
      end
      if (sch_v[s]) begin
        hold      = sch_w[s];
        have_hold = 1'b1;
      end
      if (have_hold) begin
        tests_run++;
        if ({val1, val2, val3} !== hold) begin
          tests_failed++;
          $display("[TB] FAIL stream_data step %0d: got %h %h %h want %h", k, val1, val2, val3, hold);
        end
      end
      sch_v[s] = 1'b0;
      if (k < 8)       en = 1'b1;
      else if (k < 10) en = 1'b0;
      else if (k < 13) en = 1'b1;
      else if (k < 53) en = ($urandom_range(0, 2) != 0);
      else             en = 1'b0;
      a = rand_fx();
      b = rand_fx();
      c = rand_fx();
      drive(en, a, b, c);
      if (en) begin
        sch_v[(cyc + 6) % 64] = 1'b1;
        sch_w[(cyc + 6) % 64] = {fp_model(a), fp_model(b), fp_model(c)};
      end
    end
    tests_run++;
    if (strobes < 11) begin
      tests_failed++;
      $display("[TB] FAIL stream_strobe_count: got %0d want at least 11", strobes);
    end
  endtask

  task automatic test_midflight_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 32'h0100_0000 + 32'(k), 32'hFF00_0000, 32'h0080_0000);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (valid_pack !== 1'b0 || {val1, val2, val3} !== 96'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_clear: valid=%b vals=%h %h %h, want 0", valid_pack, val1, val2, val3);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests_run++;
      if (valid_pack !== 1'b0 || {val1, val2, val3} !== 96'h0) begin
        tests_failed++;
        $display("[TB] FAIL discarded_triple cycle %0d: valid=%b vals=%h %h %h, want 0",
                 k, valid_pack, val1, val2, val3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_values();
    test_stream();
    test_midflight_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
